mmio_uart_tx: RTL

- Memory-mapped UART transmitter that sits on the core's data-memory bus (WE/A/WD/RD) beside Data_Memory and responds to core loads and stores in its address window.
- Stores to its TXDATA register queue bytes in a FIFO.
- A bit-timing state machine serialises the queued bytes as 8N1 frames, LSB first, on a single output line.

---
 rtl/mmio_uart_tx.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO behind a 16-byte register window.
// Latency: a TXDATA store at edge k makes the FIFO non-empty; the start bit drives tx after edge k+1.
// Backpressure: none on the bus; a store to a full FIFO with no same-cycle pop is dropped and sets sticky overflow.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WE,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        hit,
  output logic        tx,
  output logic        busy
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [15:0]   cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic [15:0]   active_div, adiv_n;
  logic          tx_n;
  logic          pop;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, empty, overflow;
  logic [15:0]   div;

  logic          wr_en, push_req, push_ok, status_wr, div_wr;
  logic [7:0]    fifo_rdata;
  logic          unused_bits;

  assign hit       = (A[31:4] == BASE_ADDR[31:4]);
  assign wr_en     = WE & hit;
  assign push_req  = wr_en && (A[3:2] == 2'b00);
  assign status_wr = wr_en && (A[3:2] == 2'b01);
  assign div_wr    = wr_en && (A[3:2] == 2'b10);

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign push_ok    = push_req && (!full || pop);
  assign fifo_rdata = mem[rd_ptr];
  assign busy       = (state != IDLE);

  assign unused_bits = ^{WD[31:16], A[1:0]};

  // Register read mux; silent outside the window so the top level can OR/select freely.
  always_comb begin
    RD = 32'b0;
    if (hit) begin
      case (A[3:2])
        2'b01:   RD = {28'b0, overflow, busy, empty, full};
        2'b10:   RD = {16'b0, div};
        default: RD = 32'b0;
      endcase
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= WD[7:0];
  end

  // FIFO pointers/count, sticky overflow and the baud divisor register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      div      <= DEFAULT_DIV;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full && !pop)  overflow <= 1'b1;
      else if (status_wr && WD[3])   overflow <= 1'b0;
      if (div_wr) div <= WD[15:0];
    end
  end

  // Bit-timing state register; tx is registered here so it only moves on bit boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      active_div <= DEFAULT_DIV;
      tx         <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      shift      <= shift_n;
      active_div <= adiv_n;
      tx         <= tx_n;
    end
  end

  // Next-state logic; the divisor is latched at frame start so BAUDDIV writes only affect later frames.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    adiv_n  = active_div;
    tx_n    = tx;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = fifo_rdata;
          adiv_n  = div;
          cnt_n   = '0;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (cnt == active_div) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = DATA;
          tx_n    = shift[0];
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      DATA: begin
        if (cnt == active_div) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_idx + 3'd1;
            shift_n = {1'b0, shift[7:1]};
            tx_n    = shift[1];
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      STOP: begin
        if (cnt == active_div) begin
          cnt_n = '0;
          if (!empty) begin
            // Back-to-back: skip IDLE so no extra high time appears between frames.
            pop     = 1'b1;
            shift_n = fifo_rdata;
            adiv_n  = div;
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

endmodule
